window_frame_sched: RTL and testbench
=====================================

Name: window_frame_sched

Overview:
Frame scheduler in front of the windowing stage of the spectrum sensor. It shares the single windowing/FFT datapath between NUM_CH sample streams. It grants whole frames round-robin and enforces an exact frame length of N samples toward the windower: short frames are zero-padded and long frames are truncated. It tags each output frame with its channel and keeps per-frame error status.

Parameters:
N, 1024, frame length in samples delivered downstream (power of two, >=4)
NUM_CH, 4, number of input sample streams (>=2)
DATA_W, 16, signed sample width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  scheduler enable; sampled at frame boundaries only
s_valid  in  NUM_CH  per-channel sample valid
s_ready  out  NUM_CH  per-channel ready
s_last  in  NUM_CH  per-channel upstream end-of-frame marker
s_data  in  NUM_CH*DATA_W  packed samples, channel c at bits [c*DATA_W +: DATA_W]
m_valid  out  1  sample valid to windowing stage
m_ready  in  1  windowing stage ready
m_last  out  1  asserted on sample index N-1 only
m_data  out  DATA_W  sample to windowing stage
m_chan  out  $clog2(NUM_CH)  channel of current frame, stable for the whole frame
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when the m_last beat transfers
err_short  out  1  sticky: a frame was zero-padded; cleared by reset only
err_long  out  1  sticky: a frame was truncated; cleared by reset only

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, rr_ptr=NUM_CH-1, idx=0. All outputs 0, including s_ready, m_valid, m_last, m_chan, busy, frame_done, err_short and err_long.
- States: IDLE, ARB, STREAM, PAD, DROP.
- IDLE: all s_ready=0, m_valid=0. Goes to ARB when enable=1.
- ARB: exactly one cycle. Outputs idle. Searches channels rr_ptr+1, rr_ptr+2, ... (mod NUM_CH) for the first with s_valid=1. That channel becomes grant, rr_ptr<=grant, idx<=0, and the state goes to STREAM. If no channel is valid, stays in ARB. If enable=0 in ARB, returns to IDLE.
- STREAM: zero-latency combinational pass-through of the granted channel.
  - m_valid=s_valid[grant], s_ready[grant]=m_ready, every other s_ready=0, m_data=s_data[grant], m_chan=grant.
  - A transfer (m_valid&m_ready) increments idx.
  - m_last=(idx==N-1).
- STREAM exits, evaluated on a transfer:
  - idx==N-1 and s_last[grant]=1: frame_done. Next state is ARB if enable=1, else IDLE.
  - idx==N-1 and s_last[grant]=0: frame_done, set err_long, go to DROP.
  - idx<N-1 and s_last[grant]=1: set err_short, go to PAD. m_last stays 0 on this beat.
- PAD:
  - m_valid=1, m_data=0, all s_ready=0, m_chan=grant.
  - idx increments on m_ready. m_last=(idx==N-1).
  - When the idx N-1 beat transfers: frame_done, then ARB or IDLE as above.
- DROP:
  - s_ready[grant]=1, m_valid=0.
  - Input beats of the granted channel are discarded until the beat with s_valid&s_last. The next state is then ARB or IDLE.
- Timing and handshake:
  - Round-robin fairness: a channel with data waits at most NUM_CH-1 frames.
  - Frame gap: exactly one idle cycle (ARB) between consecutive frames when upstream data is ready.
  - AXI-stream rule: m_valid, once high, is never dropped without m_ready. This is inherited from upstream in STREAM and guaranteed in PAD.
- Enable:
  - enable=0 never aborts a frame. The current frame, including PAD or DROP, completes first, then the block returns to IDLE.
- Simultaneous error events:
  - N==1 is illegal. A one-beat frame that is both full and last is the normal case.
  - The error flags only OR in new events; they are never cleared during operation.
- Counter: idx is $clog2(N) bits and never wraps inside a frame, because each exit occurs at N-1.
- Reset mid-frame: all state is lost. The next frame starts at idx 0 from ARB after enable.

Decomposition:
- Package wss_pkg holds:
  - typedef sched_state_e (IDLE, ARB, STREAM, PAD, DROP)
  - function rr_pick(valid_vec, ptr), returning the next valid channel index
  - constant CHAN_W = $clog2(NUM_CH) pattern helper
- One sub-module, rr_arbiter: a combinational priority rotate over NUM_CH requests with a pointer input. It returns the grant index and an any_valid flag.
- The FSM, idx counter, muxing and error flags live in the top-level module.

Test Plan:
(Bench uses N=8, NUM_CH=4, DATA_W=16.)
- Nominal round-robin: channels 0 and 2 each send 8-sample frames with s_last at beat 7 (data = chan*100+k). Required response: frames output in order ch0, ch2, ch0, ch2; m_chan matches; m_last on beat 7; one ARB cycle between frames; err flags stay 0.
- Short frame: ch1 sends 5 samples (10..14) with s_last on the 5th. Required response: output 10..14 then 0,0,0; m_last on the 8th beat; err_short=1; frame_done pulses once.
- Long frame: ch3 sends 11 samples, s_last on the 11th. Required response: first 8 output with m_last on the 8th; samples 9-11 consumed with s_ready=1 and m_valid=0; err_long=1; next grant follows.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly during STREAM and PAD. Required response: m_data and m_valid held while m_ready=0; no sample lost or duplicated; idx advances only on transfer.
- Enable drop: deassert enable at output beat 3 of a frame. Required response: the frame completes all 8 beats, then the block goes to IDLE with busy=0; reasserting enable resumes round-robin from rr_ptr+1.
- Async reset mid-frame: assert rst_n=0 at beat 4. Required response: all outputs 0 immediately; after release and enable, a fresh frame starts at idx 0 from ch0 (rr_ptr reset to NUM_CH-1).

Source files
------------

// File: rtl/wss_pkg.sv
// wss_pkg: shared state type and round-robin helpers for window_frame_sched
package wss_pkg;
  typedef enum logic [2:0] {IDLE, ARB, STREAM, PAD, DROP} sched_state_e;
  localparam int MAX_CH = 32;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Lowest rotated offset from ptr wins; caller checks any_valid separately.
  function automatic int rr_pick(input logic [MAX_CH-1:0] valid_vec, input int ptr, input int n);
    int c;
    rr_pick = 0;
    for (int i = n; i >= 1; i--) begin
      c = (ptr + i) % n;
      if (valid_vec[c[4:0]]) rr_pick = c;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick over NUM_CH requests starting after ptr
//   req: request vector, ptr: last granted index, grant: picked index, any_valid: some request set
module rr_arbiter import wss_pkg::*; #(
  parameter int NUM_CH = 4,
  localparam int CW = chan_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [CW-1:0]     grant,
  output logic              any_valid
);
  logic [MAX_CH-1:0] req_ext;
  assign req_ext = MAX_CH'(req);
  assign grant = CW'(rr_pick(req_ext, int'(ptr), NUM_CH));
  assign any_valid = |req;
endmodule

// File: rtl/window_frame_sched.sv
// window_frame_sched: round-robin whole-frame scheduler forcing exact N-sample frames (pad/truncate)
//   s_*: per-channel input streams, m_*: single output stream tagged with m_chan,
//   busy: not idle, frame_done: last-beat transfer, err_short/err_long: sticky pad/truncate flags
module window_frame_sched import wss_pkg::*; #(
  parameter int N = 1024,
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  localparam int CW = chan_w(NUM_CH),
  localparam int IW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH-1:0]        s_last,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [DATA_W-1:0]        m_data,
  output logic [CW-1:0]            m_chan,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_short,
  output logic                     err_long
);
  sched_state_e state, state_n, nxt;
  logic [CW-1:0] grant, rr_ptr, arb_grant;
  logic [IW-1:0] idx;
  logic any_valid, at_end, lst, take, adv, set_short, set_long;
  logic [NUM_CH-1:0] sel;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = s_data[c*DATA_W +: DATA_W];
  end
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req      (s_valid),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .any_valid(any_valid)
  );
  assign sel = NUM_CH'(1) << grant;
  assign at_end = idx == IW'(N - 1);
  assign lst = s_last[grant];
  assign nxt = enable ? ARB : IDLE;
  assign busy = state != IDLE;
  assign take = state == ARB && enable && any_valid;
  always_comb begin
    state_n = state;
    adv = 1'b0;
    set_short = 1'b0;
    set_long = 1'b0;
    s_ready = '0;
    m_valid = 1'b0;
    m_data = '0;
    m_last = 1'b0;
    m_chan = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: state_n = enable ? ARB : IDLE;
      ARB: state_n = !enable ? IDLE : any_valid ? STREAM : ARB;
      STREAM: begin
        m_valid = s_valid[grant];
        s_ready = sel & {NUM_CH{m_ready}};
        m_data = ch_data[grant];
        m_chan = grant;
        m_last = at_end;
        adv = s_valid[grant] && m_ready;
        frame_done = adv && at_end;
        set_long = adv && at_end && !lst;
        set_short = adv && !at_end && lst;
        state_n = !adv ? STREAM : at_end ? (lst ? nxt : DROP) : lst ? PAD : STREAM;
      end
      PAD: begin
        m_valid = 1'b1;
        m_chan = grant;
        m_last = at_end;
        adv = m_ready;
        frame_done = m_ready && at_end;
        state_n = frame_done ? nxt : PAD;
      end
      DROP: begin
        s_ready = sel;
        state_n = s_valid[grant] && lst ? nxt : DROP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= CW'(NUM_CH - 1);
      idx <= '0;
      err_short <= 1'b0;
      err_long <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        grant <= arb_grant;
        rr_ptr <= arb_grant;
      end
      idx <= take ? '0 : adv ? (at_end ? '0 : idx + 1'b1) : idx;
      err_short <= err_short | set_short;
      err_long <= err_long | set_long;
    end
  end
endmodule

// File: tb/tb_window_frame_sched.sv
// tb_window_frame_sched: randomized scoreboard bench against a frame-level round-robin reference model
module tb_window_frame_sched;
  localparam int N = 8, NC = 4, DW = 16;
  logic clk = 0, rst_n = 0, enable = 0, m_ready = 0;
  logic [NC-1:0] s_valid = '0, s_last = '0, s_ready;
  logic [NC*DW-1:0] s_data = '0;
  logic m_valid, m_last, busy, frame_done, err_short, err_long;
  logic [DW-1:0] m_data;
  logic [1:0] m_chan;
  window_frame_sched #(.N(N), .NUM_CH(NC), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data), .m_chan(m_chan),
    .busy(busy), .frame_done(frame_done), .err_short(err_short), .err_long(err_long)
  );
  always #5 clk = ~clk;
  int vecs = 0, miss = 0, xfers = 0, mr_mode = 0, mr_cnt = 0, mptr = NC - 1;
  bit exp_short = 0, exp_long = 0;
  logic [17:0] cq [NC][$];
  int fl [NC][$];
  logic [DW-1:0] mq [NC][$];
  logic [DW-1:0] ed [$];
  logic [1:0] ec [$];
  bit el [$];
  bit hold_prev = 0, fd_prev = 0;
  logic [DW-1:0] pd;
  logic [NC-1:0] taken;
  task automatic chk(input string nm, input int act, input int expv);
    vecs++;
    if (act != expv) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask
  task automatic add_frame(input int c, input int len, input int base, input bit rnd);
    logic [DW-1:0] d;
    for (int k = 0; k < len; k++) begin
      d = rnd ? DW'($urandom) : DW'(base + k);
      cq[c].push_back({k == 0, k == len - 1, d});
      mq[c].push_back(d);
    end
    fl[c].push_back(len);
  endtask
  // Whole frames granted round-robin; each emitted as exactly N beats.
  task automatic run_model();
    int pick, c, len;
    logic [DW-1:0] d;
    forever begin
      pick = -1;
      for (int i = 1; i <= NC; i++) begin
        c = (mptr + i) % NC;
        if (pick < 0 && fl[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      mptr = pick;
      len = fl[pick].pop_front();
      for (int k = 0; k < ((len > N) ? len : N); k++) begin
        d = (k < len) ? mq[pick].pop_front() : '0;
        if (k < N) begin
          ed.push_back(d);
          ec.push_back(2'(pick));
          el.push_back(k == N - 1);
        end
      end
      if (len < N) exp_short = 1;
      if (len > N) exp_long = 1;
    end
  endtask
  function automatic int pending();
    int s = ed.size();
    for (int c = 0; c < NC; c++) s += cq[c].size();
    return s;
  endfunction
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && pending() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", pending(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_short", err_short, exp_short);
    chk("err_long", err_long, exp_long);
  endtask
  task automatic wait_xfers(input int target, input int bound);
    for (int i = 0; i < bound && xfers < target; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_beat", xfers >= target, 1);
  endtask
  initial forever begin
    logic [17:0] e;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      taken[c] = rst_n && s_valid[c] && s_ready[c];
      if (taken[c] && cq[c].size() > 0) void'(cq[c].pop_front());
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (cq[c].size() == 0) s_valid[c] = 0;
      else begin
        e = cq[c][0];
        s_valid[c] = (s_valid[c] && !taken[c]) || e[17] || ($urandom_range(3) != 0);
        s_last[c] = e[16];
        s_data[c*DW +: DW] = e[15:0];
      end
    end
    m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? (mr_cnt % 4 == 0 || mr_cnt % 4 == 3) : ($urandom_range(2) != 0);
    mr_cnt++;
  end
  initial forever begin
    logic [DW-1:0] d;
    @(negedge clk);
    if (!rst_n) begin
      hold_prev = 0;
      fd_prev = 0;
    end else begin
      if (fd_prev) chk("gap_after_done", m_valid, 0);
      if (hold_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
      end
      if (m_valid && m_ready) begin
        xfers++;
        chk("beat_expected", ed.size() > 0, 1);
        if (ed.size() > 0) begin
          d = ed.pop_front();
          chk("data", m_data, d);
          chk("chan", m_chan, ec.pop_front());
          chk("last", m_last, el[0]);
          chk("done", frame_done, el.pop_front());
        end
      end else if (frame_done) chk("stray_done", frame_done, 0);
      hold_prev = m_valid && !m_ready;
      pd = m_data;
      fd_prev = frame_done;
    end
  end
  task automatic check_reset_outputs();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_long", err_long, 0);
  endtask
  initial begin
    #12;
    check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1;
    enable = 1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 2; f++) begin
      add_frame(0, N, 0, 0);
      add_frame(2, N, 200, 0);
    end
    run_model();
    wait_done(1000);
    @(posedge clk);
    #1;
    add_frame(1, 5, 10, 0);
    add_frame(3, 11, 300, 0);
    run_model();
    wait_done(1000);
    mr_mode = 1;
    @(posedge clk);
    #1;
    add_frame(0, 6, 0, 1);
    add_frame(1, N, 0, 1);
    add_frame(2, 3, 0, 1);
    add_frame(2, N, 0, 1);
    run_model();
    wait_done(2000);
    mr_mode = 0;
    @(posedge clk);
    #1;
    add_frame(1, N, 100, 0);
    add_frame(3, N, 300, 0);
    run_model();
    wait_xfers(xfers + 3, 500);
    enable = 0;
    for (int i = 0; i < 500 && ed.size() > N; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_disable", busy, 0);
    chk("idle_no_valid", m_valid, 0);
    chk("frame_held_back", ed.size(), N);
    enable = 1;
    wait_done(1000);
    for (int p = 0; p < 10; p++) begin
      mr_mode = (p % 3 == 0) ? 1 : 2;
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
        for (int f = $urandom_range(0, 2); f > 0; f--) add_frame(c, $urandom_range(1, 12), 0, 1);
      run_model();
      wait_done(3000);
    end
    mr_mode = 0;
    @(posedge clk);
    #1;
    add_frame(2, N, 0, 1);
    run_model();
    wait_xfers(xfers + 4, 500);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_reset_outputs();
    for (int c = 0; c < NC; c++) begin
      cq[c].delete();
      fl[c].delete();
      mq[c].delete();
    end
    ed.delete();
    ec.delete();
    el.delete();
    s_valid = '0;
    mptr = NC - 1;
    exp_short = 0;
    exp_long = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    add_frame(2, N, 20, 0);
    add_frame(0, N, 0, 0);
    run_model();
    wait_done(1000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
    $fatal(1);
  end
endmodule
